// File: rtl/rsa_prime_gate.sv
// rsa_prime_gate: trial-division qualifier for an RSA (p, q) candidate pair.
// Ports: clk, rst_n, start, p_in/q_in in; p_out/q_out, key_gen_start, busy, done, ok, reject_code out.
// Build option: define RSA_PRIME_CONST_TIME_EN for data-independent latency.
module rsa_prime_gate #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] p_in,
  input  logic [WIDTH-1:0] q_in,
  output logic [WIDTH-1:0] p_out,
  output logic [WIDTH-1:0] q_out,
  output logic             key_gen_start,
  output logic             busy,
  output logic             done,
  output logic             ok,
  output logic [1:0]       reject_code
);

  localparam int DMAX = 2**((WIDTH+1)/2) - 1;
  localparam int NDIV = DMAX - 1;
  localparam int DW   = $clog2(DMAX + 1);
  localparam int W2   = 2 * WIDTH;

  typedef enum logic [2:0] {
    IDLE,
    CHK_P,
    CHK_Q,
    DECIDE,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] p_q, p_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [DW-1:0]    d_q, d_d;
  logic             pp_q, pp_d;
  logic             qp_q, qp_d;
  logic             dec_q, dec_d;

  logic [WIDTH-1:0] p_out_d, q_out_d;
  logic             kgs_d, busy_d, done_d;
  logic             ok_d;
  logic [1:0]       code_d;

  logic [WIDTH-1:0] n;
  logic [WIDTH-1:0] dn;
  logic [W2-1:0]    dx, sq, nx;
  logic [WIDTH-1:0] rem;
  logic             last;
  logic             hit;
  logic             prime_c;
  logic             exit_c;
  logic             acc;

  assign n    = (state_q == CHK_Q) ? q_q : p_q;
  assign dn   = {{(WIDTH-DW){1'b0}}, d_q};
  assign dx   = {{(W2-DW){1'b0}}, d_q};
  assign nx   = {{WIDTH{1'b0}}, n};
  assign sq   = dx * dx;
  assign rem  = n % dn;
  assign last = (d_q == DW'(DMAX));

  // The last slot is decisive by construction: no divisor up to
  // DMAX means n is prime for every n that fits in WIDTH bits.
  always_comb begin
    hit     = 1'b1;
    prime_c = 1'b0;
    if (n < WIDTH'(2)) begin
      prime_c = 1'b0;
    end else if (sq > nx) begin
      prime_c = 1'b1;
    end else if (rem == '0) begin
      prime_c = 1'b0;
    end else if (last) begin
      prime_c = 1'b1;
    end else begin
      hit = 1'b0;
    end
  end

`ifdef RSA_PRIME_CONST_TIME_EN
  // Always walk every divisor; only the first decisive slot counts.
  assign exit_c = last;
`else
  assign exit_c = hit;
`endif

  assign acc = pp_q && qp_q && (p_q != q_q);

  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    q_d     = q_q;
    d_d     = d_q;
    pp_d    = pp_q;
    qp_d    = qp_q;
    dec_d   = dec_q;
    p_out_d = p_out;
    q_out_d = q_out;
    ok_d    = ok;
    code_d  = reject_code;
    kgs_d   = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          p_d     = p_in;
          q_d     = q_in;
          d_d     = DW'(2);
          dec_d   = 1'b0;
          state_d = CHK_P;
        end
      end
      CHK_P, CHK_Q: begin
        if (!dec_q && hit) begin
          dec_d = 1'b1;
          if (state_q == CHK_P) pp_d = prime_c;
          else                  qp_d = prime_c;
        end
        if (exit_c) begin
          d_d     = DW'(2);
          dec_d   = 1'b0;
          state_d = (state_q == CHK_P) ? CHK_Q : DECIDE;
        end else begin
          d_d = d_q + 1'b1;
        end
      end
      DECIDE: begin
        ok_d   = acc;
        kgs_d  = acc;
        done_d = 1'b1;
        if (!pp_q)           code_d = 2'b01;
        else if (!qp_q)      code_d = 2'b10;
        else if (p_q == q_q) code_d = 2'b11;
        else                 code_d = 2'b00;
        if (acc) begin
          p_out_d = p_q;
          q_out_d = q_q;
        end
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d == CHK_P) ||
             (state_d == CHK_Q) ||
             (state_d == DECIDE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      p_q           <= '0;
      q_q           <= '0;
      d_q           <= DW'(2);
      pp_q          <= 1'b0;
      qp_q          <= 1'b0;
      dec_q         <= 1'b0;
      p_out         <= '0;
      q_out         <= '0;
      key_gen_start <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      ok            <= 1'b0;
      reject_code   <= 2'b00;
    end else begin
      state_q       <= state_d;
      p_q           <= p_d;
      q_q           <= q_d;
      d_q           <= d_d;
      pp_q          <= pp_d;
      qp_q          <= qp_d;
      dec_q         <= dec_d;
      p_out         <= p_out_d;
      q_out         <= q_out_d;
      key_gen_start <= kgs_d;
      busy          <= busy_d;
      done          <= done_d;
      ok            <= ok_d;
      reject_code   <= code_d;
    end
  end

  // NDIV documents the slot count per check; it has no logic of its own.
  logic unused_ndiv;
  assign unused_ndiv = (NDIV == 0);

endmodule
